// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the system RAM arbiter: ownership states and default burst/guard sizes.
// The loader imports the same constants so its burst assumptions track the arbiter.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      StCpu   = 2'd0,
      StDma   = 2'd1,
      StGuard = 2'd2
   } arb_state_e;

   localparam int unsigned DefMaxBurst = 4;
   localparam int unsigned DefCpuMin   = 2;

   // Counter width for a range of n values; a single value still needs one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port registered-read RAM between the 6502 core and the DMA/loader master.
// The CPU owns the RAM by default; DMA steals bounded bursts, each followed by a CPU guard window.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned AW        = 16,
   parameter int unsigned DW        = 8,
   parameter int unsigned MAX_BURST = DefMaxBurst,
   parameter int unsigned CPU_MIN   = DefCpuMin
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_dout,
   input  logic          cpu_we,
   output logic [DW-1:0] cpu_din,
   output logic          cpu_rdy,
   input  logic          dma_req,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_dout,
   input  logic          dma_we,
   output logic          dma_ack,
   output logic [DW-1:0] dma_din,
   output logic          dma_rvalid,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata
);

   localparam int unsigned BW = cnt_width(MAX_BURST);
   localparam int unsigned GW = cnt_width(CPU_MIN);
   localparam logic [BW-1:0] BurstLast = BW'(MAX_BURST - 1);
   localparam logic [GW-1:0] GuardLoad = GW'(CPU_MIN - 1);

   arb_state_e    state_q, state_d;
   logic [BW-1:0] burst_cnt_q, burst_cnt_d;
   logic [GW-1:0] guard_cnt_q, guard_cnt_d;
   logic          own_dma;
   logic          prev_cpu_q;
   logic          dma_rvalid_q;
   logic [DW-1:0] hold_q;

   assign own_dma = (state_q == StDma);

   always_comb begin
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      guard_cnt_d = guard_cnt_q;
      unique case (state_q)
         StCpu: begin
            if (dma_req) begin
               state_d     = StDma;
               burst_cnt_d = '0;
            end
         end
         StDma: begin
            // An idle cycle (request dropped) ends the burst just like the last acked cycle.
            if (!dma_req || (burst_cnt_q == BurstLast)) begin
               state_d     = StGuard;
               guard_cnt_d = GuardLoad;
            end else begin
               burst_cnt_d = burst_cnt_q + 1'b1;
            end
         end
         StGuard: begin
            if (guard_cnt_q == '0) begin
               if (dma_req) begin
                  state_d     = StDma;
                  burst_cnt_d = '0;
               end else begin
                  state_d = StCpu;
               end
            end else begin
               guard_cnt_d = guard_cnt_q - 1'b1;
            end
         end
         default: state_d = StCpu;
      endcase
   end

   always_comb begin
      cpu_rdy    = !own_dma;
      dma_ack    = own_dma & dma_req;
      mem_addr   = own_dma ? dma_addr : cpu_addr;
      mem_wdata  = own_dma ? dma_dout : cpu_dout;
      mem_we     = own_dma ? (dma_we & dma_req) : cpu_we;
      // Across a stall the CPU keeps seeing the result of its last performed cycle.
      cpu_din    = prev_cpu_q ? mem_rdata : hold_q;
      dma_din    = mem_rdata;
      dma_rvalid = dma_rvalid_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StCpu;
         burst_cnt_q  <= '0;
         guard_cnt_q  <= '0;
         prev_cpu_q   <= 1'b1;
         dma_rvalid_q <= 1'b0;
         hold_q       <= '0;
      end else begin
         state_q      <= state_d;
         burst_cnt_q  <= burst_cnt_d;
         guard_cnt_q  <= guard_cnt_d;
         prev_cpu_q   <= !own_dma;
         dma_rvalid_q <= dma_ack & !dma_we;
         if (prev_cpu_q) begin
            hold_q <= mem_rdata;
         end
      end
   end

endmodule
